// File: rtl/countdown_timer_bcd.sv
// Loadable MM:SS BCD countdown timer with a 1 Hz prescaler and IDLE/RUN/PAUSE/DONE run control.
// Optional auto-reload on reaching 00:00 is enabled by defining COUNTDOWN_AUTO_RELOAD_EN.
module countdown_timer_bcd #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        start,
    input  logic        stop,
    output logic [3:0]  min_t,
    output logic [3:0]  min_o,
    output logic [3:0]  sec_t,
    output logic [3:0]  sec_o,
    output logic        running,
    output logic        done,
    output logic        expired
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);

    logic [1:0]       state_q, state_d;
    logic [15:0]      time_q, time_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic             done_q, done_d;
    logic             running_q, running_d;
    logic             expired_q, expired_d;

    logic [15:0]      load_clamped;
    logic [15:0]      time_dec;
    logic             b0, b1, b2;
    logic             tick;
    logic             tick_zero;
    logic             time_zero;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [15:0]      reload_q, reload_d;
`endif

    function automatic logic [3:0] clamp_digit(input logic [3:0] v, input logic [3:0] max);
        return (v > max) ? max : v;
    endfunction

    always_comb begin
        load_clamped = {clamp_digit(load_val[15:12], 4'd9), clamp_digit(load_val[11:8], 4'd9),
                        clamp_digit(load_val[7:4], 4'd5), clamp_digit(load_val[3:0], 4'd9)};
    end

    // Borrow chain: each digit only moves when every lower digit wrapped.
    always_comb begin
        time_dec       = time_q;
        b0             = (time_q[3:0] == 4'd0);
        time_dec[3:0]  = b0 ? 4'd9 : time_q[3:0] - 4'd1;
        b1             = b0 && (time_q[7:4] == 4'd0);
        if (b0) time_dec[7:4] = b1 ? 4'd5 : time_q[7:4] - 4'd1;
        b2             = b1 && (time_q[11:8] == 4'd0);
        if (b1) time_dec[11:8] = b2 ? 4'd9 : time_q[11:8] - 4'd1;
        if (b2) time_dec[15:12] = (time_q[15:12] == 4'd0) ? 4'd9 : time_q[15:12] - 4'd1;
    end

    assign tick      = (state_q == S_RUN) && (presc_q == TICK_MAX);
    assign time_zero = (time_q == 16'h0000);
    // 00:01 decrements to zero; 00:00 itself is treated as reached so it can never wrap to 99:59.
    assign tick_zero = (time_q == 16'h0001) || time_zero;

    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        presc_d  = presc_q;
        done_d   = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        if (load && (state_q != S_RUN)) begin
            state_d  = S_IDLE;
            time_d   = load_clamped;
            presc_d  = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_d = load_clamped;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_PAUSE: begin
                    if (start) begin
                        if (time_zero) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_RUN;
                            if (state_q == S_IDLE) presc_d = '0;
                        end
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_d = S_PAUSE;
                    end else if (tick) begin
                        presc_d = '0;
                        if (tick_zero) begin
                            done_d  = 1'b1;
                            time_d  = 16'h0000;
                            state_d = S_DONE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            if (reload_q != 16'h0000) begin
                                time_d  = reload_q;
                                state_d = S_RUN;
                            end
`endif
                        end else begin
                            time_d = time_dec;
                        end
                    end else begin
                        presc_d = presc_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
        running_d = (state_d == S_RUN);
        expired_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            time_q    <= '0;
            presc_q   <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            presc_q   <= presc_d;
            done_q    <= done_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) reload_q <= '0;
        else     reload_q <= reload_d;
    end
`endif

    assign min_t   = time_q[15:12];
    assign min_o   = time_q[11:8];
    assign sec_t   = time_q[7:4];
    assign sec_o   = time_q[3:0];
    assign running = running_q;
    assign done    = done_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Bench for countdown_timer_bcd with TICK_DIV=4; expected digit values go through a scoreboard queue.
module tb_countdown_timer_bcd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [3:0]  min_t, min_o, sec_t, sec_o;
    logic        running, done, expired;
    logic [15:0] digits;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          d0;

    countdown_timer_bcd #(.TICK_DIV(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start), .stop(stop),
        .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
        .running(running), .done(done), .expired(expired)
    );

    assign digits = {min_t, min_o, sec_t, sec_o};

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [15:0] v);
        load = 1'b1; load_val = v;
        tick_n(1);
        load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick_n(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick_n(1);
        stop = 1'b0;
    endtask

    task automatic test_reset();
        tick_n(3);
        checks++; if ({digits, running, done, expired} !== 19'h0) begin errors++;
            $display("FAIL reset_state: got %h expected 0", {digits, running, done, expired}); end
        rst = 1'b0;
        tick_n(1);
    endtask

    task automatic test_basic();
        d0 = done_cnt;
        pulse_load(16'h0003);
        pulse_start();
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0001);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        exp_q.push_back(16'h0003);
`else
        exp_q.push_back(16'h0000);
`endif
        tick_n(3);
        checks++; if (digits !== 16'h0003) begin errors++;
            $display("FAIL basic_pre_tick: got %h expected %h", digits, 16'h0003); end
        tick_n(1);
        exp_v = exp_q.pop_front();
        checks++; if (digits !== exp_v) begin errors++;
            $display("FAIL basic_tick1: got %h expected %h", digits, exp_v); end
        tick_n(4);
        exp_v = exp_q.pop_front();
        checks++; if ({digits, done} !== {exp_v, 1'b0}) begin errors++;
            $display("FAIL basic_tick2: got %h expected %h", {digits, done}, {exp_v, 1'b0}); end
        tick_n(4);
        exp_v = exp_q.pop_front();
        checks++; if (digits !== exp_v) begin errors++;
            $display("FAIL basic_tick3: got %h expected %h", digits, exp_v); end
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        checks++; if ({done, running, expired} !== 3'b110) begin errors++;
            $display("FAIL basic_zero_flags: got %b expected 110", {done, running, expired}); end
        tick_n(1);
        checks++; if ({done, running, expired} !== 3'b010) begin errors++;
            $display("FAIL basic_after_flags: got %b expected 010", {done, running, expired}); end
        pulse_stop();
`else
        checks++; if ({done, running, expired} !== 3'b101) begin errors++;
            $display("FAIL basic_zero_flags: got %b expected 101", {done, running, expired}); end
        tick_n(1);
        checks++; if ({done, running, expired} !== 3'b001) begin errors++;
            $display("FAIL basic_after_flags: got %b expected 001", {done, running, expired}); end
`endif
        checks++; if (done_cnt - d0 !== 1) begin errors++;
            $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_borrow();
        pulse_load(16'h0100);
        pulse_start();
        exp_q.push_back(16'h0059);
        tick_n(4);
        exp_v = exp_q.pop_front();
        checks++; if (digits !== exp_v) begin errors++;
            $display("FAIL borrow_0100: got %h expected %h", digits, exp_v); end
        pulse_stop();
        pulse_load(16'h1000);
        pulse_start();
        exp_q.push_back(16'h0959);
        tick_n(4);
        exp_v = exp_q.pop_front();
        checks++; if (digits !== exp_v) begin errors++;
            $display("FAIL borrow_1000: got %h expected %h", digits, exp_v); end
        pulse_stop();
    endtask

    task automatic test_pause();
        int frozen_bad;
        frozen_bad = 0;
        pulse_load(16'h0005);
        pulse_start();
        exp_q.push_back(16'h0004);
        exp_q.push_back(16'h0003);
        tick_n(4);
        exp_v = exp_q.pop_front();
        checks++; if (digits !== exp_v) begin errors++;
            $display("FAIL pause_first_tick: got %h expected %h", digits, exp_v); end
        tick_n(2);
        pulse_stop();
        checks++; if (running !== 1'b0) begin errors++;
            $display("FAIL pause_running: got %b expected 0", running); end
        for (int i = 0; i < 20; i++) begin
            tick_n(1);
            if (digits !== 16'h0004) frozen_bad++;
        end
        checks++; if (frozen_bad !== 0) begin errors++;
            $display("FAIL pause_frozen: got %0d changed cycles expected 0", frozen_bad); end
        pulse_start();
        tick_n(1);
        checks++; if ({digits, running} !== {16'h0004, 1'b1}) begin errors++;
            $display("FAIL pause_resume_hold: got %h expected %h", {digits, running}, {16'h0004, 1'b1}); end
        tick_n(1);
        exp_v = exp_q.pop_front();
        checks++; if (digits !== exp_v) begin errors++;
            $display("FAIL pause_resume_tick: got %h expected %h", digits, exp_v); end
        pulse_stop();
    endtask

    task automatic test_clamp_and_guards();
        pulse_load(16'hFF7C);
        exp_q.push_back(16'h9959);
        exp_v = exp_q.pop_front();
        checks++; if (digits !== exp_v) begin errors++;
            $display("FAIL clamp: got %h expected %h", digits, exp_v); end
        pulse_start();
        pulse_load(16'h0100);
        checks++; if ({digits, running} !== {16'h9959, 1'b1}) begin errors++;
            $display("FAIL load_in_run: got %h expected %h", {digits, running}, {16'h9959, 1'b1}); end
        pulse_stop();
        load = 1'b1; start = 1'b1; load_val = 16'h0030;
        tick_n(1);
        load = 1'b0; start = 1'b0;
        checks++; if ({digits, running, expired} !== {16'h0030, 2'b00}) begin errors++;
            $display("FAIL load_start: got %h expected %h", {digits, running, expired}, {16'h0030, 2'b00}); end
        tick_n(3);
        checks++; if (digits !== 16'h0030) begin errors++;
            $display("FAIL idle_hold: got %h expected %h", digits, 16'h0030); end
        pulse_load(16'h0000);
        d0 = done_cnt;
        pulse_start();
        checks++; if ({done, running, expired} !== 3'b101) begin errors++;
            $display("FAIL start_zero: got %b expected 101", {done, running, expired}); end
        tick_n(1);
        checks++; if ({done, running, expired, done_cnt - d0 == 1} !== 4'b0011) begin errors++;
            $display("FAIL start_zero_after: got %b expected 0011", {done, running, expired, done_cnt - d0 == 1}); end
    endtask

    task automatic test_async_reset();
        pulse_load(16'h0040);
        pulse_start();
        tick_n(2);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        checks++; if ({digits, running, done, expired} !== 19'h0) begin errors++;
            $display("FAIL async_reset: got %h expected 0", {digits, running, done, expired}); end
        tick_n(2);
        rst = 1'b0;
        tick_n(2);
        checks++; if ({digits, running, done_cnt - d0 == 0} !== {16'h0000, 2'b01}) begin errors++;
            $display("FAIL async_reset_after: got %h expected %h", {digits, running, done_cnt - d0 == 0}, {16'h0000, 2'b01}); end
    endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        pulse_load(16'h0002);
        pulse_start();
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) exp_q.push_back(i[0] ? 16'h0002 : 16'h0001);
        for (int i = 0; i < 4; i++) begin
            tick_n(4);
            exp_v = exp_q.pop_front();
            checks++; if ({digits, done, running, expired} !== {exp_v, i[0], 2'b10}) begin errors++;
                $display("FAIL auto_reload_%0d: got %h expected %h", i, {digits, done, running, expired}, {exp_v, i[0], 2'b10}); end
        end
        checks++; if (done_cnt - d0 !== 2) begin errors++;
            $display("FAIL auto_reload_done_count: got %0d expected 2", done_cnt - d0); end
        pulse_stop();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_pause();
        test_clamp_and_guards();
        test_async_reset();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        test_auto_reload();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer_bcd.md
Name: countdown_timer_bcd

Overview:
- Loadable MM:SS countdown timer. It is the down-counting, borrow-chain complement to the team's mod-6/mod-10 up-counters with carry-out, used by the digital clock for the timer/alarm mode.
- An internal prescaler divides clk into 1 Hz second ticks.
- Four BCD digits are decremented with borrow propagation under a small run-control FSM.
- Digit outputs drive the existing 7-segment scan logic directly.

Parameters:
- TICK_DIV, 50000000, clk cycles per second tick; must be >= 2. Benches use 4.
- CNT_W, 26, prescaler counter width; must satisfy 2**CNT_W >= TICK_DIV.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high. Clears all state.
- load  input  1  one-cycle pulse: capture load_val as the new time.
- load_val  input  16  BCD {min_t, min_o, sec_t, sec_o}, 4 bits each.
- start  input  1  one-cycle pulse: begin or resume counting.
- stop  input  1  one-cycle pulse: pause counting.
- min_t  output  4  minutes tens digit, 0..9.
- min_o  output  4  minutes ones digit, 0..9.
- sec_t  output  4  seconds tens digit, 0..5.
- sec_o  output  4  seconds ones digit, 0..9.
- running  output  1  high while state == RUN.
- done  output  1  one-cycle pulse when the count reaches 00:00.
- expired  output  1  level, high while state == DONE.

Behaviour:
- Reset (async, rst=1): state IDLE, all digits 0, prescaler 0, running/done/expired 0, reload register 0.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Load:
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - Digits are clamped: min_t/min_o/sec_o values > 9 become 9; sec_t values > 5 become 5.
  - Digits and the reload register update on the next edge.
  - Next state is IDLE; prescaler cleared; expired cleared.
- Start:
  - In IDLE or PAUSE with time != 00:00, go to RUN on the next edge.
  - From IDLE the prescaler is cleared. From PAUSE the prescaler is retained, so partial seconds are preserved.
  - Start with time == 00:00 goes to DONE and pulses done on the same edge.
  - Start is ignored in RUN and DONE.
- Stop:
  - In RUN, go to PAUSE on the next edge; digits and prescaler are frozen.
  - Ignored in all other states.
- Simultaneous events (priority): load > stop > start.
  - load with start in the same cycle: apply the load, ignore start.
  - stop with start in RUN: go to PAUSE.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN and wraps to 0.
  - A tick occurs on the cycle the count equals TICK_DIV-1.
  - First decrement comes TICK_DIV cycles after RUN is entered from IDLE.
- Decrement (on tick):
  - sec_o: if >0 subtract 1, else set to 9 and borrow.
  - sec_t: on borrow, if >0 subtract 1, else set to 5 and borrow.
  - min_o: on borrow, same rule with wrap value 9.
  - min_t: on borrow, same rule with wrap value 9.
  - 00:00 is never decremented: the check for reaching zero happens before any wrap is possible.
- Zero reached: when a tick makes the result 00:00, go to DONE on the same edge and assert done for exactly 1 cycle. expired stays 1 until load or rst.
- Maximum load is 99:59, which takes 5999 ticks to reach zero.
- Reset asserted mid-RUN returns to IDLE with 00:00 immediately (asynchronously), with no done pulse.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined: on reaching 00:00 in RUN, done pulses 1 cycle. On that same edge the digits reload from the reload register and the state stays RUN (expired never asserts). If the reload value is 00:00, go to DONE as normal.
- Undefined: the reload register is not synthesized, and behaviour is exactly as specified above.

Test Plan:
- TICK_DIV=4. Reset, then load 00:03, then start. Digits follow 00:02, 00:01, 00:00 at 4, 8 and 12 cycles after RUN entry. done pulses once at 00:00. expired=1 and running=0 afterward.
- Load 01:00, start, one tick. Result is 00:59, with borrow propagating across sec_o, sec_t and min_o. Load 10:00, one tick: result is 09:59.
- Load 00:05, start, stop after 6 cycles, hold 20 cycles, start again. Digits stay frozen during PAUSE. Next decrement comes 2 cycles after resume because the prescaler is retained.
- Load 0xFF7C: result is clamped to 99:59 (digits 9,9,5,9). Load during RUN is ignored. Same-cycle load+start leaves state IDLE. Start at 00:00 gives an immediate done pulse.
- Assert rst asynchronously between clock edges mid-RUN at 00:40. Outputs go to 0 and state to IDLE before the next edge, with no done pulse.
- With COUNTDOWN_AUTO_RELOAD_EN defined, load 00:02 and start. done pulses every 8 cycles, digits cycle 00:01, 00:02, …, running stays 1 and expired stays 0.
